// File: rtl/fwl_pkg.sv
// Shared types and constants for the flowing-light LED controller family.
package fwl_pkg;

    typedef enum logic [1:0] {
        FWL_UP     = 2'b00,
        FWL_DOWN   = 2'b01,
        FWL_BOUNCE = 2'b10,
        FWL_FILL   = 2'b11
    } fwl_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } fwl_dir_e;

    localparam logic LED_ON = 1'b0;

endpackage

// File: rtl/fwl_prescaler.sv
// Programmable step prescaler: emits a one-cycle step every div+1 enabled cycles.
module fwl_prescaler #(
    parameter int unsigned DIV_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 en_i,
    input  logic                 load_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 step_c_o
);

    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;

    assign step_c_o = en_i && (cnt_q == div_i);

    // load restarts the period even while disabled
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (step_c_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flowing_light_ctrl.sv
// N-bit active-low LED chaser with rotate-up/down, bounce and fill patterns.
// Bounce mode and its direction register exist only when FWL_BOUNCE_EN is defined.
module flowing_light_ctrl
    import fwl_pkg::*;
#(
    parameter int unsigned N_LEDS    = 16,
    parameter int unsigned DIV_WIDTH = 24,
    localparam int unsigned POS_W    = $clog2(N_LEDS)
) (
    input  logic                 clk,
    input  logic                 n_reset,
    input  logic                 en,
    input  logic                 load,
    input  logic [1:0]           mode,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [N_LEDS-1:0]    out,
    output logic [POS_W-1:0]     pos,
    output logic                 wrap
);

    localparam logic [POS_W-1:0] POS_MAX = POS_W'(N_LEDS - 1);

    logic             step_c;
    logic [POS_W-1:0] pos_q, pos_d;
    logic             wrap_q, wrap_d;
    fwl_mode_e        mode_sel, mode_q, mode_d;
`ifdef FWL_BOUNCE_EN
    fwl_dir_e         dir_q, dir_d, dir_eff;
`endif

    fwl_prescaler #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_prescaler (
        .clk     (clk),
        .n_reset (n_reset),
        .en_i    (en),
        .load_i  (load),
        .div_i   (div),
        .step_c_o(step_c)
    );

    assign mode_sel = fwl_mode_e'(mode);

    // Next-state: the mode sampled on a step governs that same step
    always_comb begin
        pos_d  = pos_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
`ifdef FWL_BOUNCE_EN
        dir_d   = dir_q;
        dir_eff = (mode_sel != mode_q) ? DIR_UP : dir_q;
`endif
        if (load) begin
            pos_d  = '0;
            mode_d = mode_sel;
`ifdef FWL_BOUNCE_EN
            dir_d  = DIR_UP;
`endif
        end else if (step_c) begin
            mode_d = mode_sel;
`ifdef FWL_BOUNCE_EN
            dir_d  = DIR_UP;
`endif
            case (mode_sel)
                FWL_DOWN: begin
                    if (pos_q == '0) begin
                        pos_d  = POS_MAX;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q - POS_W'(1);
                    end
                end
`ifdef FWL_BOUNCE_EN
                FWL_BOUNCE: begin
                    // Direction flips on arrival at an end, so the ends never dwell
                    if (dir_eff == DIR_UP) begin
                        if (pos_q == POS_MAX) begin
                            pos_d = pos_q - POS_W'(1);
                            dir_d = DIR_DOWN;
                        end else begin
                            pos_d = pos_q + POS_W'(1);
                            dir_d = (pos_d == POS_MAX) ? DIR_DOWN : DIR_UP;
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d = POS_W'(1);
                            dir_d = DIR_UP;
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                            dir_d = (pos_d == '0) ? DIR_UP : DIR_DOWN;
                        end
                    end
                    wrap_d = (pos_d == '0);
                end
`endif
                default: begin
                    if (pos_q == POS_MAX) begin
                        pos_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        pos_d = pos_q + POS_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            pos_q  <= '0;
            mode_q <= FWL_UP;
            wrap_q <= 1'b0;
`ifdef FWL_BOUNCE_EN
            dir_q  <= DIR_UP;
`endif
        end else begin
            pos_q  <= pos_d;
            mode_q <= mode_d;
            wrap_q <= wrap_d;
`ifdef FWL_BOUNCE_EN
            dir_q  <= dir_d;
`endif
        end
    end

    // LED decode from registered position and mode
    always_comb begin
        out = '1;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            if (mode_q == FWL_FILL) begin
                if (POS_W'(i) <= pos_q) out[i] = LED_ON;
            end else if (POS_W'(i) == pos_q) begin
                out[i] = LED_ON;
            end
        end
    end

    assign pos  = pos_q;
    assign wrap = wrap_q;

endmodule

// File: doc/flowing_light_ctrl.md
# flowing_light_ctrl

Parametrised successor to the fixed 16-LED chaser: drives an N-bit active-low LED bank with one lit position (or a growing bar) that advances on a programmable tick. It supports rotate-up, rotate-down, bounce and fill modes, with enable and restart controls. It sits between the board clock and the LED pins and replaces fixed-width, fixed-direction chasers in lab designs.

## Interface
- N_LEDS, 16, number of LEDs; legal range 2..64
- DIV_WIDTH, 24, width of the tick divider
- clk  input  1  system clock; all state changes on its rising edge
- n_reset  input  1  reset, asynchronous, active-low
- en  input  1  level; 1 lets the prescaler run, 0 freezes all state
- load  input  1  single-cycle synchronous restart
- mode  input  2  00 rotate-up, 01 rotate-down, 10 bounce, 11 fill
- div  input  DIV_WIDTH  step period minus one, in clk cycles
- out  output  N_LEDS  LED drive, active-low (0 = lit)
- pos  output  $clog2(N_LEDS)  current position
- wrap  output  1  one-cycle pulse when a pattern cycle completes

## Operation
- **Prescaler:** count `cnt` runs 0..div while en=1. `step` is asserted when cnt==div and en=1, and cnt returns to 0 on that cycle. With div=0, step occurs every enabled cycle. With en=0, cnt, pos, dir, mode_r and wrap all hold, and wrap is 0.
- **Mode latch:** mode is sampled into mode_r only on a step or a load. Mid-period mode changes take effect at the next step. pos is preserved across a mode change. dir is set to up whenever mode_r changes.
- **Step behaviour, by mode_r:**
  - Rotate-up: pos+1, with N_LEDS-1 → 0; wrap on that transition.
  - Rotate-down: pos-1, with 0 → N_LEDS-1; wrap on that transition.
  - Bounce: dir up → pos+1 until N_LEDS-1, then dir flips down. Dir down → pos-1 until 0, then dir flips up. There is no dwell at the ends: sequence 0,1,…,N-1,N-2,…,0,1. wrap on the step where pos becomes 0.
  - Fill: pos+1, with N_LEDS-1 → 0; wrap on that transition.
- **Decode:** out is combinational from registered pos and mode_r.
  - Single-dot modes: out = ~(1 << pos).
  - Fill: out[i] = 0 for i ≤ pos, else 1.
- **load:** has priority over step. It sets pos=0, dir=up, cnt=0 and mode_r=mode, and forces wrap=0. load works regardless of en.
- **Reset values:** pos=0, dir=up, cnt=0, mode_r=00, wrap=0, out = all ones except bit 0 (bit 0 lit).

## Timing
- pos, dir, wrap and mode_r update on the rising edge at which step=1. out follows in the same cycle via the decode.
- Steady-state period is div+1 cycles.
- After deassertion of n_reset or a load, the first step occurs div+1 enabled cycles later.
- wrap is high for exactly one clk cycle, aligned with the new pos.
- If div changes mid-count and cnt > new div, cnt continues to counter wrap-around. This is permitted; users change div only with load or en=0.
- Asynchronous reset mid-operation returns all state to the reset values immediately. There is no partial-step state.

## Configuration
- Macro: FWL_BOUNCE_EN.
- **Defined:** mode 10 is bounce as described, and the dir register exists.
- **Undefined:** the dir register is removed, and mode 10 behaves exactly as rotate-up, including wrap.

## Structure
- **Package fwl_pkg:** mode typedef enum (FWL_UP=2'b00, FWL_DOWN=2'b01, FWL_BOUNCE=2'b10, FWL_FILL=2'b11), the dir typedef (DIR_UP, DIR_DOWN), and the LED_ON=1'b0 constant.
- **Sub-module fwl_prescaler:** cnt, div, en, load → step. It is reused by other timed display blocks.
- **Top:** holds pos, dir, mode_r, the next-state logic and the decode.

## Test plan
- **Reset and rotate-up** (N_LEDS=8, div=2, mode=00, en=1): release reset. out=8'hFE, then 8'hFD after 3 cycles, then every 3 cycles. After 8 steps, pos=0, out=8'hFE, wrap=1 for one cycle.
- **Rotate-down** (div=0, mode=01): the first step gives pos=7, out=8'h7F, wrap=1. The next step gives pos=6, out=8'hBF.
- **Bounce** (div=0, mode=10): pos sequence 0,1,…,7,6,…,0,1. wrap fires only on the 1→0 step. Without FWL_BOUNCE_EN, pos sequence is 0..7,0.
- **Fill** (div=0, mode=11): out is 8'hFE, 8'hFC, 8'hF8, …, 8'h00, then 8'hFE with wrap=1.
- **en and load:** drop en for 5 cycles mid-period; pos, cnt and out hold and no wrap occurs. Pulse load at pos=5 with en=0: next cycle pos=0, out=8'hFE, and cnt restarts from 0.
- **Mid-period mode change:** switch mode 00→01 at pos=3, one cycle into a period with div=4. pos stays 3 until the step, then becomes 2.
